// File: rtl/lpm_chan_queue.sv
// lpm_chan_queue: DEPTH-entry FIFO between a say() producer and NCHAN
// heard() indication channels, routed by the low bits of meth.
module lpm_chan_queue #(
  parameter int DEPTH = 4,
  parameter int MW    = 32,
  parameter int VW    = 32,
  parameter int NCHAN = 2,
  localparam int CW   = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             say__ENA,
  input  logic [MW-1:0]    say_meth,
  input  logic [VW-1:0]    say_v,
  output logic             say__RDY,
  output logic [NCHAN-1:0] indication_heard__ENA,
  output logic [MW-1:0]    indication_heard_meth,
  output logic [VW-1:0]    indication_heard_v,
  input  logic [NCHAN-1:0] indication_heard__RDY,
  input  logic             rule_enable,
  output logic             rule_ready,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [MW+VW-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    ch;
  logic             enq;
  logic             fire;

  assign {indication_heard_meth, indication_heard_v} = mem[rp];

  generate
    if (NCHAN > 1) begin : g_sel
      assign ch = indication_heard_meth[CW-1:0];
    end else begin : g_one
      assign ch = '0;
    end
  endgenerate

  // full is judged on stored occupancy only; a same-cycle dequeue
  // does not reopen the buffer
  assign say__RDY   = (count != FULL);
  assign enq        = say__ENA && say__RDY;
  assign rule_ready = (count != '0) && indication_heard__RDY[ch];
  assign fire       = rule_enable && rule_ready;

  always_comb begin
    indication_heard__ENA = '0;
    if (fire) indication_heard__ENA[ch] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (enq) mem[wp] <= {say_meth, say_v};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (enq)  wp <= wp + 1'b1;
      if (fire) rp <= rp + 1'b1;
      unique case (1'b1)
        (enq && !fire): count <= count + 1'b1;
        (fire && !enq): count <= count - 1'b1;
        default:        count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_lpm_chan_queue.sv
// tb_lpm_chan_queue: directed vector table plus hand sequences for
// wrap, head-of-line, async reset and single-channel routing.
module tb_lpm_chan_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        say_ena;
  logic [31:0] say_meth;
  logic [31:0] say_v;
  logic        say_rdy;
  logic [1:0]  heard_ena;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic [1:0]  heard_rdy;
  logic        rule_en;
  logic        rule_rdy;
  logic [2:0]  count;

  logic        s1_ena;
  logic [31:0] s1_meth;
  logic [31:0] s1_v;
  logic        s1_rdy;
  logic [0:0]  h1_ena;
  logic [31:0] h1_meth;
  logic [31:0] h1_v;
  logic [0:0]  h1_rdy;
  logic        r1_en;
  logic        r1_rdy;
  logic [1:0]  c1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lpm_chan_queue u_dut (
    .CLK                   (clk),
    .nRST                  (rst_n),
    .say__ENA              (say_ena),
    .say_meth              (say_meth),
    .say_v                 (say_v),
    .say__RDY              (say_rdy),
    .indication_heard__ENA (heard_ena),
    .indication_heard_meth (heard_meth),
    .indication_heard_v    (heard_v),
    .indication_heard__RDY (heard_rdy),
    .rule_enable           (rule_en),
    .rule_ready            (rule_rdy),
    .count                 (count)
  );

  lpm_chan_queue #(.DEPTH(2), .NCHAN(1)) u_one (
    .CLK                   (clk),
    .nRST                  (rst_n),
    .say__ENA              (s1_ena),
    .say_meth              (s1_meth),
    .say_v                 (s1_v),
    .say__RDY              (s1_rdy),
    .indication_heard__ENA (h1_ena),
    .indication_heard_meth (h1_meth),
    .indication_heard_v    (h1_v),
    .indication_heard__RDY (h1_rdy),
    .rule_enable           (r1_en),
    .rule_ready            (r1_rdy),
    .count                 (c1)
  );

  typedef struct {
    logic        se;
    logic [31:0] m;
    logic [31:0] v;
    logic [1:0]  rdy;
    logic        re;
    logic        e_srdy;
    logic        e_rr;
    logic [1:0]  e_ena;
    logic        chk_d;
    logic [31:0] e_m;
    logic [31:0] e_v;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    logic se, logic [31:0] m, logic [31:0] v, logic [1:0] rdy,
    logic re, logic e_srdy, logic e_rr, logic [1:0] e_ena,
    logic chk_d, logic [31:0] e_m, logic [31:0] e_v, logic [2:0] e_cnt
  );
    tbl.push_back('{se, m, v, rdy, re, e_srdy, e_rr, e_ena,
                    chk_d, e_m, e_v, e_cnt});
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic se, logic [31:0] m, logic [31:0] v,
                       logic [1:0] rdy, logic re);
    say_ena   = se;
    say_meth  = m;
    say_v     = v;
    heard_rdy = rdy;
    rule_en   = re;
  endtask

  task automatic step(logic se, logic [31:0] m, logic [31:0] v,
                      logic [1:0] rdy, logic re);
    @(posedge clk);
    #1 drive(se, m, v, rdy, re);
  endtask

  task automatic run_vec(int i, vec_t t);
    string s;
    step(t.se, t.m, t.v, t.rdy, t.re);
    @(negedge clk);
    s = $sformatf("row%0d", i);
    chk({s, ".say_rdy"}, 64'(say_rdy), 64'(t.e_srdy));
    chk({s, ".rule_ready"}, 64'(rule_rdy), 64'(t.e_rr));
    chk({s, ".ena"}, 64'(heard_ena), 64'(t.e_ena));
    chk({s, ".count"}, 64'(count), 64'(t.e_cnt));
    if (t.chk_d) begin
      chk({s, ".meth"}, 64'(heard_meth), 64'(t.e_m));
      chk({s, ".v"}, 64'(heard_v), 64'(t.e_v));
    end
  endtask

  logic [63:0] q[$];
  logic [63:0] hd;
  logic [31:0] m_new;
  logic [31:0] v_new;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 2'b11, 1'b0);
    s1_ena = 1'b0; s1_meth = '0; s1_v = '0; h1_rdy = 1'b1; r1_en = 1'b0;
    #1;
    chk("rst.say_rdy", 64'(say_rdy), 64'd1);
    chk("rst.rule_ready", 64'(rule_rdy), 64'd0);
    chk("rst.ena", 64'(heard_ena), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // basic, fill/drain, head-of-line
    add(0, 0,     0,     2'b11, 1, 1, 0, 2'b00, 0, 0,     0,     0);
    add(1, 'h10,  'hAA,  2'b11, 1, 1, 0, 2'b00, 0, 0,     0,     0);
    add(0, 0,     0,     2'b11, 1, 1, 1, 2'b01, 1, 'h10,  'hAA,  1);
    add(0, 0,     0,     2'b11, 1, 1, 0, 2'b00, 0, 0,     0,     0);
    add(1, 'h20,  1,     2'b11, 0, 1, 0, 2'b00, 0, 0,     0,     0);
    add(1, 'h21,  2,     2'b11, 0, 1, 1, 2'b00, 1, 'h20,  1,     1);
    add(1, 'h22,  3,     2'b11, 0, 1, 1, 2'b00, 1, 'h20,  1,     2);
    add(1, 'h23,  4,     2'b11, 0, 1, 1, 2'b00, 1, 'h20,  1,     3);
    add(1, 'h30,  5,     2'b11, 0, 0, 1, 2'b00, 1, 'h20,  1,     4);
    add(1, 'h31,  6,     2'b11, 1, 0, 1, 2'b01, 1, 'h20,  1,     4);
    add(0, 0,     0,     2'b11, 1, 1, 1, 2'b10, 1, 'h21,  2,     3);
    add(0, 0,     0,     2'b11, 1, 1, 1, 2'b01, 1, 'h22,  3,     2);
    add(0, 0,     0,     2'b11, 1, 1, 1, 2'b10, 1, 'h23,  4,     1);
    add(0, 0,     0,     2'b11, 1, 1, 0, 2'b00, 0, 0,     0,     0);
    add(1, 'h3,   'h33,  2'b01, 0, 1, 0, 2'b00, 0, 0,     0,     0);
    add(1, 'h2,   'h22,  2'b01, 1, 1, 0, 2'b00, 1, 'h3,   'h33,  1);
    add(0, 0,     0,     2'b01, 1, 1, 0, 2'b00, 1, 'h3,   'h33,  2);
    add(0, 0,     0,     2'b10, 1, 1, 1, 2'b10, 1, 'h3,   'h33,  2);
    add(0, 0,     0,     2'b10, 1, 1, 0, 2'b00, 1, 'h2,   'h22,  1);
    add(0, 0,     0,     2'b01, 1, 1, 1, 2'b01, 1, 'h2,   'h22,  1);
    add(0, 0,     0,     2'b11, 1, 1, 0, 2'b00, 0, 0,     0,     0);
    foreach (tbl[i]) run_vec(i, tbl[i]);

    // concurrent enqueue/dequeue at count=2, pointers wrap
    for (int i = 0; i < 2; i++) begin
      m_new = 32'h100 + 32'(i);
      v_new = $urandom;
      step(1'b1, m_new, v_new, 2'b11, 1'b0);
      q.push_back({m_new, v_new});
    end
    for (int i = 0; i < 20; i++) begin
      m_new = 32'h200 + 32'(i * 3);
      v_new = $urandom;
      step(1'b1, m_new, v_new, 2'b11, 1'b1);
      @(negedge clk);
      hd = q.pop_front();
      q.push_back({m_new, v_new});
      chk("conc.count", 64'(count), 64'd2);
      chk("conc.say_rdy", 64'(say_rdy), 64'd1);
      chk("conc.ena", 64'(heard_ena), 64'(2'b01 << hd[32]));
      chk("conc.meth", 64'(heard_meth), 64'(hd[63:32]));
      chk("conc.v", 64'(heard_v), 64'(hd[31:0]));
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, '0, 2'b11, 1'b1);
      @(negedge clk);
      hd = q.pop_front();
      chk("drain.meth", 64'(heard_meth), 64'(hd[63:32]));
      chk("drain.v", 64'(heard_v), 64'(hd[31:0]));
    end
    step(1'b0, '0, '0, 2'b11, 1'b0);
    @(negedge clk);
    chk("drain.count", 64'(count), 64'd0);

    // async reset mid-cycle with three entries queued
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + 32'(i), 32'(i), 2'b11, 1'b0);
    step(1'b0, '0, '0, 2'b11, 1'b1);
    #1;
    chk("pre_rst.count", 64'(count), 64'd3);
    chk("pre_rst.ena", 64'(heard_ena), 64'b01);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.say_rdy", 64'(say_rdy), 64'd1);
    chk("arst.rule_ready", 64'(rule_rdy), 64'd0);
    chk("arst.ena", 64'(heard_ena), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.count", 64'(count), 64'd0);
    step(1'b1, 32'h55, 32'h77, 2'b11, 1'b1);
    step(1'b0, '0, '0, 2'b11, 1'b1);
    @(negedge clk);
    chk("post_rst.ena", 64'(heard_ena), 64'b10);
    chk("post_rst.meth", 64'(heard_meth), 64'h55);
    chk("post_rst.v", 64'(heard_v), 64'h77);
    step(1'b0, '0, '0, 2'b11, 1'b0);

    // single-channel build ignores meth for routing
    @(posedge clk);
    #1 s1_ena = 1'b1; s1_meth = 32'h1; s1_v = 32'hA1; r1_en = 1'b1;
    @(negedge clk);
    chk("one.empty_ena", 64'(h1_ena), 64'd0);
    @(posedge clk);
    #1 s1_meth = 32'h3; s1_v = 32'hA3;
    @(negedge clk);
    chk("one.ena0", 64'(h1_ena), 64'd1);
    chk("one.meth0", 64'(h1_meth), 64'h1);
    @(posedge clk);
    #1 s1_meth = 32'h2; s1_v = 32'hA2;
    @(negedge clk);
    chk("one.ena1", 64'(h1_ena), 64'd1);
    chk("one.meth1", 64'(h1_meth), 64'h3);
    @(posedge clk);
    #1 s1_ena = 1'b0;
    @(negedge clk);
    chk("one.ena2", 64'(h1_ena), 64'd1);
    chk("one.meth2", 64'(h1_meth), 64'h2);
    chk("one.v2", 64'(h1_v), 64'hA2);
    @(posedge clk);
    #1 r1_en = 1'b0;
    @(negedge clk);
    chk("one.count", 64'(c1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
